// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory access arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;
    localparam int NUM_REQ    = 2;
    localparam int GNT_W      = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        CLEAR  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arb_rr_select.sv
// Two-way round-robin picker; owns the last_grant register.
module mem_arb_rr_select
    import mem_arb_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               load,
    output logic [GNT_W-1:0]   gnt,
    output logic               valid
);

    logic [GNT_W-1:0] last_grant_reg;

    // Lone requester wins; on a tie the requester that did not win last time goes.
    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        if (req[0] && req[1]) begin
            gnt = ~last_grant_reg;
        end else if (req[1]) begin
            gnt = 1'b1;
        end
    end

    // Remember the winner each time a request is accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_reg <= 1'b1;
        end else if (load) begin
            last_grant_reg <= gnt;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter and sequencer for the 128x8 register-file memory.
// Optional build macro MEM_ARB_CLEAR_EN: zero the whole memory after reset
// release before accepting any request.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      init_done,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_read_enable,
    output logic                      mem_write_enable,
    input  logic [DATA_W-1:0]         mem_rdata
);

    state_t             state_reg, state_next;
    logic [GNT_W-1:0]   gnt_sel, gnt_reg;
    logic               sel_valid;
    logic               load;
    logic               we_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [DATA_W-1:0]  rdata_reg;
    logic               init_done_reg;
    logic               outputs_live;

`ifdef MEM_ARB_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
    logic [ADDR_W:0]    clr_cnt_reg;
    logic [ADDR_W:0]    clr_next;

    assign clr_next = clr_cnt_reg + (ADDR_W+1)'(1);
    // The FSM sits in CLEAR while reset is held, so gate outputs with reset.
    assign outputs_live = reset;
`else
    localparam state_t RESET_STATE = IDLE;
    assign outputs_live = 1'b1;
`endif

    mem_arb_rr_select u_rr_select (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .load  (load),
        .gnt   (gnt_sel),
        .valid (sel_valid)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= RESET_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    load       = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: state_next = RESP;
            RESP:   state_next = IDLE;
            CLEAR: begin
`ifdef MEM_ARB_CLEAR_EN
                if (clr_next[ADDR_W]) begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the winning request; during CLEAR the address register walks the memory.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (load) begin
            gnt_reg   <= gnt_sel;
            we_reg    <= we[gnt_sel];
            addr_reg  <= addr[gnt_sel*ADDR_W +: ADDR_W];
            wdata_reg <= wdata[gnt_sel*DATA_W +: DATA_W];
`ifdef MEM_ARB_CLEAR_EN
        end else if (state_reg == CLEAR && !clr_next[ADDR_W]) begin
            addr_reg  <= clr_next[ADDR_W-1:0];
`endif
        end
    end

    // Capture read data at the edge closing ACCESS; a write reports zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_reg <= '0;
        end else if (state_reg == ACCESS) begin
            rdata_reg <= we_reg ? '0 : mem_rdata;
        end
    end

`ifdef MEM_ARB_CLEAR_EN
    // Clear counter; init_done rises once the counter MSB sets.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clr_cnt_reg   <= '0;
            init_done_reg <= 1'b0;
        end else if (state_reg == CLEAR) begin
            clr_cnt_reg <= clr_next;
            if (clr_next[ADDR_W]) begin
                init_done_reg <= 1'b1;
            end
        end
    end
`else
    // Ready from the first clock after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            init_done_reg <= 1'b0;
        end else begin
            init_done_reg <= 1'b1;
        end
    end
`endif

    // Decode memory strobes, ack and busy from the current state.
    always_comb begin
        ack              = '0;
        busy             = 1'b0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        if (outputs_live) begin
            busy = (state_reg != IDLE);
            if (state_reg == RESP) begin
                ack[gnt_reg] = 1'b1;
            end
            if (state_reg == ACCESS) begin
                mem_write_enable = we_reg;
                mem_read_enable  = ~we_reg;
            end
            if (state_reg == CLEAR) begin
                mem_write_enable = 1'b1;
            end
        end
    end

    assign rdata     = rdata_reg;
    assign init_done = init_done_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural 128x8 memory and
// an expected-ack scoreboard.
module tb_mem_access_arbiter;

    localparam int AW = 7;
    localparam int DW = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [1:0]      req   = '0;
    logic [1:0]      we    = '0;
    logic [2*AW-1:0] addr  = '0;
    logic [2*DW-1:0] wdata = '0;
    logic [1:0]      ack;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            init_done;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            mem_read_enable;
    logic            mem_write_enable;

    logic [DW-1:0]   mem_model [0:(1<<AW)-1];

    typedef struct {
        int          id;
        logic [7:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    // Register-file memory: write at posedge, combinational read.
    always @(posedge clock) begin
        if (mem_write_enable) mem_model[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem_model[mem_addr];

    mem_access_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .req              (req),
        .we               (we),
        .addr             (addr),
        .wdata            (wdata),
        .ack              (ack),
        .rdata            (rdata),
        .busy             (busy),
        .init_done        (init_done),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_rdata        (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
        end
    endtask

    // Compare an ack against the oldest scoreboard entry.
    task automatic score_ack(input string tag);
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.id = -1;
            e.rd = 8'h00;
        end
        check({tag, "_ack"}, 32'(ack), 32'(1) << e.id);
        check({tag, "_rdata"}, 32'(rdata), 32'(e.rd));
        $display("txn %s: ack=%b rdata=%02h", tag, ack, rdata);
    endtask

    // One access from IDLE: drive at posedge+1, expect strobe in cycle 1 and ack in cycle 2.
    task automatic do_access(input string tag, input int id, input logic w,
                             input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW-1:0] exp_rd);
        int   n;
        logic saw_en;
        logic saw_busy;
        exp_t e;
        req[id]            = 1'b1;
        we[id]             = w;
        addr[id*AW +: AW]  = a;
        wdata[id*DW +: DW] = d;
        e.id = id;
        e.rd = w ? 8'h00 : exp_rd;
        sb.push_back(e);
        saw_en   = 1'b0;
        saw_busy = 1'b0;
        for (n = 0; n < 10; n++) begin
            @(negedge clock);
            if (n == 1) begin
                saw_en   = w ? mem_write_enable : mem_read_enable;
                saw_busy = busy;
            end
            if (ack != 2'b00) break;
        end
        check({tag, "_latency"}, 32'(n), 32'd2);
        check({tag, "_strobe"}, 32'(saw_en), 32'd1);
        check({tag, "_busy"}, 32'(saw_busy), 32'd1);
        if (ack != 2'b00) score_ack(tag);
        else void'(sb.pop_front());
        @(posedge clock);
        #1;
        req[id] = 1'b0;
    endtask

    initial begin
        // Reset state.
        @(negedge clock);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_we_en", 32'(mem_write_enable), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

`ifdef MEM_ARB_CLEAR_EN
        begin
            int   k;
            exp_t e;
            @(negedge clock);
            reset = 1'b0;
            req[0] = 1'b1;
            we[0]  = 1'b0;
            addr[0 +: AW] = 7'h7F;
            e.id = 0;
            e.rd = 8'h00;
            sb.push_back(e);
            @(negedge clock);
            reset = 1'b1;
            for (k = 1; k < 128; k++) begin
                @(negedge clock);
                check("clr_no_ack", 32'(ack), 32'd0);
                check("clr_init_low", 32'(init_done), 32'd0);
            end
            for (k = 128; k < 140; k++) begin
                @(negedge clock);
                if (ack != 2'b00) break;
            end
            check("clr_ack_cycle", 32'(k), 32'd130);
            check("clr_init_high", 32'(init_done), 32'd1);
            if (ack != 2'b00) score_ack("clr_read7f");
            @(posedge clock);
            #1;
            req = '0;
        end
`else
        // Test 1: reset dropped during an ACCESS.
        req[0] = 1'b1;
        we[0]  = 1'b1;
        addr[0 +: AW]  = 7'h20;
        wdata[0 +: DW] = 8'h77;
        @(negedge clock);
        @(negedge clock);
        check("t1_access_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("t1_ack", 32'(ack), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_we_en", 32'(mem_write_enable), 32'd0);
        check("t1_rd_en", 32'(mem_read_enable), 32'd0);
        check("t1_rdata", 32'(rdata), 32'd0);
        check("t1_mem_addr", 32'(mem_addr), 32'd0);
        check("t1_mem_wdata", 32'(mem_wdata), 32'd0);
        check("t1_init_done", 32'(init_done), 32'd0);
        req = '0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("t1_init_after", 32'(init_done), 32'd1);
        check("t1_busy_after", 32'(busy), 32'd0);

        // Test 2: write then read back from the other requester.
        do_access("t2_wr0", 0, 1'b1, 7'h05, 8'hA5, 8'h00);
        do_access("t2_rd1", 1, 1'b0, 7'h05, 8'h00, 8'hA5);

        // Test 3: both requesters held from reset release alternate 0,1,0.
        begin
            exp_t e;
            logic [1:0] exp_ack;
            @(negedge clock);
            reset = 1'b0;
            req   = 2'b11;
            we    = 2'b00;
            addr  = {7'h05, 7'h05};
            e.rd = 8'hA5;
            e.id = 0; sb.push_back(e);
            e.id = 1; sb.push_back(e);
            e.id = 0; sb.push_back(e);
            @(negedge clock);
            reset = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clock);
                exp_ack = (k == 2 || k == 8) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00;
                check($sformatf("t3_ack_c%0d", k), 32'(ack), 32'(exp_ack));
                if (ack != 2'b00) score_ack($sformatf("t3_c%0d", k));
            end
            check("t3_sb_empty", 32'(sb.size()), 32'd0);
            sb.delete();
            @(posedge clock);
            #1;
            req = '0;
        end

        // Test 4: a write cut by reset must not reach the memory.
        do_access("t4_wr3c", 0, 1'b1, 7'h10, 8'h3C, 8'h00);
        req[0] = 1'b1;
        we[0]  = 1'b1;
        addr[0 +: AW]  = 7'h10;
        wdata[0 +: DW] = 8'hC3;
        @(negedge clock);
        @(negedge clock);
        check("t4_we_before", 32'(mem_write_enable), 32'd1);
        reset = 1'b0;
        #1;
        check("t4_we_dropped", 32'(mem_write_enable), 32'd0);
        @(posedge clock);
        #1;
        req = '0;
        @(negedge clock);
        check("t4_no_ack", 32'(ack), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        do_access("t4_rd10", 0, 1'b0, 7'h10, 8'h00, 8'h3C);

        // Test 5: top and bottom addresses, no aliasing.
        do_access("t5_wr7f", 0, 1'b1, 7'h7F, 8'hFF, 8'h00);
        do_access("t5_wr00", 1, 1'b1, 7'h00, 8'h01, 8'h00);
        do_access("t5_rd7f", 1, 1'b0, 7'h7F, 8'h00, 8'hFF);
        do_access("t5_rd00", 0, 1'b0, 7'h00, 8'h00, 8'h01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
